ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16: instruction word-address width.
REQ-002 Parameter RESET_VEC, default 0: PC value after reset.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST_F  input  1  reset, asynchronous, active-low.
REQ-005 FETCH_EN  input  1  ctrl permission to start a new fetch.
REQ-006 BR_TAKEN  input  1  one-cycle pulse: redirect PC to BR_ADDR.
REQ-007 BR_ADDR  input  ADDR_W  branch target word address.
REQ-008 IM_REQ  output  1  instruction-memory read request.
REQ-009 IM_ADDR  output  ADDR_W  instruction-memory read address.
REQ-010 IM_ACK  input  1  memory response strobe; IM_DATA valid this cycle.
REQ-011 IM_DATA  input  32  instruction word from memory.
REQ-012 IR  output  32  registered instruction to datapath (opcode IR[31:28], MM IR[27:24]).
REQ-013 IR_VALID  output  1  IR holds an unconsumed instruction.
REQ-014 IR_READY  input  1  datapath accepts IR this cycle.
REQ-015 PC  output  ADDR_W  address of next instruction to fetch.
REQ-016 HALTED  output  1  fetch stopped on HALT opcode.

Function
REQ-017 FSM states: IDLE, REQ, FLUSH, HOLD, HALT; state register only.
REQ-018 IDLE: FETCH_EN=1 -> REQ next cycle; else stay.
REQ-019 REQ: IM_REQ=1, IM_ADDR=PC; both held stable until IM_ACK=1.
REQ-020 REQ with IM_ACK=1, no BR_TAKEN: IR<=IM_DATA, IR_VALID<=1, PC<=PC+1 modulo 2^ADDR_W, -> HOLD; fetch latency = 1 cycle after ACK.
REQ-021 HOLD: IR and IR_VALID stable while IR_READY=0; IR_READY=1 -> IR_VALID<=0, next state REQ if FETCH_EN=1 else IDLE.
REQ-022 BR_TAKEN in IDLE or HOLD: PC<=BR_ADDR, IR_VALID<=0, IR unchanged, -> IDLE.
REQ-023 BR_TAKEN in REQ without IM_ACK: PC<=BR_ADDR, IM_REQ/IM_ADDR stay on old request, -> FLUSH.
REQ-024 FLUSH: IM_REQ=1 with old address until IM_ACK; response discarded (IR, IR_VALID, PC untouched) -> IDLE.
REQ-025 BR_TAKEN coincident with IM_ACK in REQ: branch wins, data discarded, PC<=BR_ADDR, -> IDLE.
REQ-026 BR_TAKEN coincident with IR_READY in HOLD: branch wins; instruction counts consumed.
REQ-027 PC wrap: 2^ADDR_W-1 increments to 0 silently.
REQ-028 IM_ACK outside REQ/FLUSH ignored.

Reset
REQ-029 RST_F=0 asynchronously forces: state IDLE, PC=RESET_VEC, IR=0, IR_VALID=0, IM_REQ=0, IM_ADDR=RESET_VEC, HALTED=0.
REQ-030 Reset mid-request abandons the transaction; a stale IM_ACK after release is ignored per REQ-028.

Configuration
REQ-031 Macro IFETCH_HALT_EN defined: instruction with IR[31:28]=4'hF enters HOLD normally; on its IR_READY -> HALT; HALT: HALTED=1, IM_REQ=0, FETCH_EN/BR_TAKEN ignored until reset.
REQ-032 Macro absent: HALT state not built, HALTED tied 0, opcode 4'hF fetched like any other.

Structure
REQ-033 Shared package sisc_pkg holds FSM state enum, OP_HALT=4'hF, default ADDR_W and RESET_VEC.
REQ-034 One sub-module pc_counter: loadable ADDR_W register with increment, async reset to RESET_VEC.

Verification
REQ-035 Reset then FETCH_EN=1, memory ACK 2 cycles after REQ with 32'h1234_5678 at addr 0 -> IR=32'h1234_5678, IR_VALID=1, PC=1.
REQ-036 IR_READY held 0 for 5 cycles in HOLD -> IR stable, IM_REQ=0; IR_READY=1 -> next IM_ADDR=1.
REQ-037 BR_TAKEN, BR_ADDR=16'h0040 during outstanding REQ at addr 3 -> IM_ADDR stays 3 until ACK, data discarded, next request IM_ADDR=16'h0040.
REQ-038 PC=16'hFFFF fetch acknowledged -> PC=0; BR_TAKEN coincident with IM_ACK -> IR unchanged, PC=BR_ADDR.
REQ-039 IFETCH_HALT_EN: fetch 32'hF000_0000, consume -> HALTED=1, no further IM_REQ despite FETCH_EN; RST_F low -> HALTED=0, PC=RESET_VEC.
REQ-040 RST_F asserted mid-REQ -> IM_REQ=0 same cycle without clock; late IM_ACK ignored.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encodings,
// the HALT opcode and default geometry.
package sisc_pkg;

    localparam int          DEF_ADDR_W    = 16;
    localparam int unsigned DEF_RESET_VEC = 0;

    localparam logic [3:0]  OP_HALT       = 4'hF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_FLUSH = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_HALT  = 3'd4;

endpackage

// File: rtl/ifetch_unit_pc_counter.sv
// Program counter: loadable ADDR_W register with wrap-around increment.
// A load takes priority over an increment.
module pc_counter
    import sisc_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int unsigned RESET_VEC = DEF_RESET_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    // PC update: branch load, sequential increment (wraps silently), or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RST_VAL;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ONE;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, holds the
// returned instruction in IR until the datapath takes it, and redirects on
// branches. A branch that lands while a read is outstanding lets that read
// finish (FLUSH) and throws the response away.
// Optional build macro IFETCH_HALT_EN: consuming an opcode 4'hF instruction
// parks the unit in HALT until reset. Without it HALTED is tied low.
module ifetch_unit
    import sisc_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int unsigned RESET_VEC = DEF_RESET_VEC
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              FETCH_EN,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_ADDR,
    output logic              IM_REQ,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic              IM_ACK,
    input  logic [31:0]       IM_DATA,
    output logic [31:0]       IR,
    output logic              IR_VALID,
    input  logic              IR_READY,
    output logic [ADDR_W-1:0] PC,
    output logic              HALTED
);

    localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_VEC);

    state_t state;
    state_t state_nxt;
    logic   pc_load;
    logic   pc_inc;
    logic   ir_load;
    logic   ir_vld_clr;
    logic   addr_load;

    pc_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RESET_VEC)
    ) u_pc (
        .clk      (CLK),
        .rst_n    (RST_F),
        .load     (pc_load),
        .load_val (BR_ADDR),
        .inc      (pc_inc),
        .pc       (PC)
    );

    // Next-state and datapath control; a branch always beats ACK/READY
    always_comb begin
        state_nxt  = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        ir_load    = 1'b0;
        ir_vld_clr = 1'b0;
        addr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (BR_TAKEN) begin
                    pc_load = 1'b1;
                end else if (FETCH_EN) begin
                    addr_load = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (BR_TAKEN) begin
                    pc_load   = 1'b1;
                    state_nxt = IM_ACK ? ST_IDLE : ST_FLUSH;
                end else if (IM_ACK) begin
                    ir_load   = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                // A further branch while draining just retargets the PC
                if (BR_TAKEN) begin
                    pc_load = 1'b1;
                end
                if (IM_ACK) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (BR_TAKEN) begin
                    pc_load    = 1'b1;
                    ir_vld_clr = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (IR_READY) begin
                    ir_vld_clr = 1'b1;
`ifdef IFETCH_HALT_EN
                    if (IR[31:28] == OP_HALT) begin
                        state_nxt = ST_HALT;
                    end else
`endif
                    if (FETCH_EN) begin
                        addr_load = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef IFETCH_HALT_EN
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request address is captured on entry to REQ so it survives a FLUSH
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            IM_ADDR <= RST_VAL;
        end else if (addr_load) begin
            IM_ADDR <= PC;
        end
    end

    // Instruction register and its valid flag
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            IR       <= '0;
            IR_VALID <= 1'b0;
        end else begin
            if (ir_load) begin
                IR <= IM_DATA;
            end
            if (ir_load) begin
                IR_VALID <= 1'b1;
            end else if (ir_vld_clr) begin
                IR_VALID <= 1'b0;
            end
        end
    end

    assign IM_REQ = (state == ST_REQ) || (state == ST_FLUSH);

`ifdef IFETCH_HALT_EN
    assign HALTED = (state == ST_HALT);
`else
    assign HALTED = 1'b0;
`endif

endmodule
